// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_ctrl
// Purpose  : Command-side initiator for a registered 2-bit ALU. Host commands
//            are queued in a small FIFO. They are issued one at a time to the
//            ALU inputs. After the ALU register latency has passed, the 3-bit
//            result is captured into a tagged response that waits for the host
//            to accept it (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // host command port
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_a,
  input  logic [1:0]                    cmd_b,
  input  logic                          cmd_cin,
  input  logic [1:0]                    cmd_fun,
  input  logic [TAG_W-1:0]              cmd_tag,
  // ALU drive / result
  output logic [1:0]                    alu_a,
  output logic [1:0]                    alu_b,
  output logic                          alu_cin,
  output logic [1:0]                    alu_fun,
  input  logic [2:0]                    alu_out,
  // host response port
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2:0]                    rsp_data,
  output logic [TAG_W-1:0]              rsp_tag,
  // status
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_level
);

  localparam int                c_ADDR_W    = $clog2(FIFO_DEPTH);
  localparam int                c_ENTRY_W   = 7 + TAG_W;
  localparam logic [c_ADDR_W:0] c_DEPTH_CNT = (c_ADDR_W + 1)'(FIFO_DEPTH);

  // The issue sequence always runs IDLE -> WAIT -> CAPTURE -> RESP. In RESP, the
  // handshake edge can also issue the next command and jump straight to WAIT.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                 r_state;

  logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]    r_wr_ptr;
  logic [c_ADDR_W-1:0]    r_rd_ptr;
  logic [c_ADDR_W:0]      r_count;

  logic [1:0]             r_alu_a;
  logic [1:0]             r_alu_b;
  logic                   r_alu_cin;
  logic [1:0]             r_alu_fun;
  logic [TAG_W-1:0]       r_inflight_tag;
  logic                   r_rsp_valid;
  logic [2:0]             r_rsp_data;
  logic [TAG_W-1:0]       r_rsp_tag;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [c_ENTRY_W-1:0]   w_push_entry;
  logic [c_ENTRY_W-1:0]   w_head;
  logic [1:0]             w_head_a;
  logic [1:0]             w_head_b;
  logic                   w_head_cin;
  logic [1:0]             w_head_fun;
  logic [TAG_W-1:0]       w_head_tag;

  // The full flag comes only from the registered count. A pop in the same cycle
  // never opens a slot for a push.
  assign w_full    = (r_count == c_DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  // Pop decisions also use the registered count. An entry pushed into an
  // empty FIFO therefore becomes visible to the FSM on the following edge.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));

  // Entry layout, MSB first: {a, b, cin, fun, tag}
  assign w_push_entry = {cmd_a, cmd_b, cmd_cin, cmd_fun, cmd_tag};
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_tag   = w_head[TAG_W-1:0];
  assign w_head_fun   = w_head[TAG_W+1:TAG_W];
  assign w_head_cin   = w_head[TAG_W+2];
  assign w_head_b     = w_head[TAG_W+4:TAG_W+3];
  assign w_head_a     = w_head[TAG_W+6:TAG_W+5];

  // Command storage. The contents do not need a reset because the count
  // decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the depth
  // is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/capture sequencer. It owns every registered ALU and response output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_cin      <= 1'b0;
      r_alu_fun      <= '0;
      r_inflight_tag <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_tag      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_a        <= w_head_a;
            r_alu_b        <= w_head_b;
            r_alu_cin      <= w_head_cin;
            r_alu_fun      <= w_head_fun;
            r_inflight_tag <= w_head_tag;
            r_state        <= S_WAIT;
          end
        end
        // The ALU registers its result on this edge.
        S_WAIT: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rsp_data  <= alu_out;
          r_rsp_tag   <= r_inflight_tag;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              r_alu_a        <= w_head_a;
              r_alu_b        <= w_head_b;
              r_alu_cin      <= w_head_cin;
              r_alu_fun      <= w_head_fun;
              r_inflight_tag <= w_head_tag;
              r_state        <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_fun   = r_alu_fun;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign cmd_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_ctrl
// Purpose  : Directed, table-driven bench for alu_cmd_ctrl. It includes a
//            behavioural model of the registered 2-bit ALU that the block
//            drives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic       cmd_cin;
  logic [1:0] cmd_fun;
  logic [3:0] cmd_tag;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic       alu_cin;
  logic [1:0] alu_fun;
  logic [2:0] alu_out = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_data;
  logic [3:0] rsp_tag;
  logic       busy;
  logic [2:0] cmd_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int exp_d   [8];
  int exp_t   [8];
  int got_cyc [8];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic [1:0] fun;
    logic [3:0] tag;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [9];

  alu_cmd_ctrl #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cin   (cmd_cin),
    .cmd_fun   (cmd_fun),
    .cmd_tag   (cmd_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_fun   (alu_fun),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy),
    .cmd_level (cmd_level)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure the spacing between responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU responder: 00 add, 10 sub, 01 a>>1, 11 b>>1.
  always @(posedge clk) begin
    case (alu_fun)
      2'b00:   alu_out <= {1'b0, alu_a} + {1'b0, alu_b} + {2'b00, alu_cin};
      2'b10:   alu_out <= {1'b0, alu_a} - {1'b0, alu_b};
      2'b01:   alu_out <= {2'b00, alu_a[1]};
      default: alu_out <= {2'b00, alu_b[1]};
    endcase
  end

  // Watchdog: stop the run if it ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_data"},  rsp_data,  0);
    check({pfx, "_rsp_tag"},   rsp_tag,   0);
    check({pfx, "_alu_in"},    {alu_a, alu_b, alu_cin, alu_fun}, 0);
    check({pfx, "_busy"},      busy,      0);
    check({pfx, "_cmd_level"}, cmd_level, 0);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
  endtask

  // Called at a negedge. Presents one command for a single edge and returns at
  // the following negedge with cmd_valid dropped.
  task automatic push(input logic [1:0] a, input logic [1:0] b, input logic cin,
                      input logic [1:0] fun, input logic [3:0] tag, output bit acc);
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_fun   = fun;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    acc       = cmd_ready;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // With rsp_ready=1, collect n responses and compare them with exp_d/exp_t.
  task automatic collect(input string pfx, input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!rsp_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check({pfx, "_rsp_present"}, rsp_valid, 1);
      check({pfx, "_rsp_data"}, rsp_data, exp_d[i]);
      check({pfx, "_rsp_tag"},  rsp_tag,  exp_t[i]);
      got_cyc[i] = cyc;
      @(negedge clk);
    end
  endtask

  initial begin
    bit acc;
    int n_acc;
    int stale;

    // Vector table: {a, b, cin, fun, tag, expected result}
    vecs[0] = '{2'd3, 2'd3, 1'b1, 2'b00, 4'h5, 3'd7};
    vecs[1] = '{2'd0, 2'd1, 1'b0, 2'b10, 4'h1, 3'd7};
    vecs[2] = '{2'd3, 2'd0, 1'b0, 2'b01, 4'h2, 3'd1};
    vecs[3] = '{2'd0, 2'd2, 1'b0, 2'b11, 4'h3, 3'd1};
    vecs[4] = '{2'd2, 2'd3, 1'b0, 2'b00, 4'h9, 3'd5};
    vecs[5] = '{2'd3, 2'd3, 1'b0, 2'b00, 4'hA, 3'd6};
    vecs[6] = '{2'd1, 2'd3, 1'b0, 2'b10, 4'hC, 3'd6};
    vecs[7] = '{2'd2, 2'd1, 1'b0, 2'b01, 4'hF, 3'd1};
    vecs[8] = '{2'd3, 2'd1, 1'b0, 2'b11, 4'h6, 3'd0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_cin   = 1'b0;
    cmd_fun   = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;

    // Reset outputs: before the first clock edge, while held in reset, and idle
    // after release.
    #1;
    check_reset("rst_async");
    repeat (3) @(negedge clk);
    check_reset("rst_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst_idle");

    // Single-command vectors: fixed three-edge latency, handshake on the first
    // valid edge.
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].fun, vecs[i].tag, acc);
      check("vec_accept", acc, 1);
      check("vec_e0_level", cmd_level, 1);
      check("vec_e0_busy", busy, 1);
      check("vec_e0_valid", rsp_valid, 0);
      @(negedge clk);
      check("vec_e1_alu_in", {alu_a, alu_b, alu_cin, alu_fun},
            {vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].fun});
      check("vec_e1_level", cmd_level, 0);
      check("vec_e1_valid", rsp_valid, 0);
      @(negedge clk);
      check("vec_e2_valid", rsp_valid, 0);
      @(negedge clk);
      check("vec_e3_valid", rsp_valid, 1);
      check("vec_e3_data", rsp_data, vecs[i].exp);
      check("vec_e3_tag", rsp_tag, vecs[i].tag);
      @(negedge clk);
      check("vec_e4_valid", rsp_valid, 0);
      check("vec_e4_busy", busy, 0);
    end

    // Back-to-back: sub wrap, a>>1, b>>1 with one response every 3 cycles.
    push(2'd0, 2'd1, 1'b0, 2'b10, 4'h7, acc);
    push(2'd3, 2'd0, 1'b0, 2'b01, 4'h8, acc);
    push(2'd3, 2'd2, 1'b0, 2'b11, 4'h9, acc);
    exp_d[0] = 7; exp_t[0] = 7;
    exp_d[1] = 1; exp_t[1] = 8;
    exp_d[2] = 1; exp_t[2] = 9;
    collect("b2b", 3);
    check("b2b_gap01", got_cyc[1] - got_cyc[0], 3);
    check("b2b_gap12", got_cyc[2] - got_cyc[1], 3);
    check("b2b_busy_end", busy, 0);

    // Full FIFO under backpressure.
    rsp_ready = 1'b0;
    n_acc = 0;
    push(2'd1, 2'd2, 1'b0, 2'b00, 4'h1, acc); n_acc += int'(acc);
    push(2'd2, 2'd3, 1'b1, 2'b00, 4'h2, acc); n_acc += int'(acc);
    push(2'd1, 2'd2, 1'b0, 2'b10, 4'h3, acc); n_acc += int'(acc);
    push(2'd3, 2'd1, 1'b0, 2'b10, 4'h4, acc); n_acc += int'(acc);
    push(2'd0, 2'd3, 1'b0, 2'b11, 4'h5, acc); n_acc += int'(acc);
    check("full_accepted", n_acc, 5);
    cmd_a = 2'd3; cmd_b = 2'd3; cmd_cin = 1'b1; cmd_fun = 2'b00; cmd_tag = 4'h6;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("full_cmd_ready", cmd_ready, 0);
      check("full_level", cmd_level, 4);
      check("full_alu_stable", {alu_a, alu_b, alu_cin, alu_fun}, {2'd1, 2'd2, 1'b0, 2'b00});
      check("full_rsp_valid", rsp_valid, 1);
      check("full_rsp_data", rsp_data, 3);
      check("full_rsp_tag", rsp_tag, 1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_d[0] = 3; exp_t[0] = 1;
    exp_d[1] = 6; exp_t[1] = 2;
    exp_d[2] = 7; exp_t[2] = 3;
    exp_d[3] = 2; exp_t[3] = 4;
    exp_d[4] = 1; exp_t[4] = 5;
    collect("drain", 5);
    @(negedge clk);
    check("drain_level", cmd_level, 0);
    check("drain_busy", busy, 0);
    check("drain_no_sixth", rsp_valid, 0);

    // Push and pop on the same edge starting from level 2.
    rsp_ready = 1'b0;
    push(2'd1, 2'd1, 1'b0, 2'b00, 4'h3, acc);
    push(2'd2, 2'd2, 1'b1, 2'b00, 4'h4, acc);
    push(2'd2, 2'd3, 1'b0, 2'b10, 4'h5, acc);
    begin
      int w = 0;
      while (!rsp_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    check("pp_first_valid", rsp_valid, 1);
    check("pp_first_data", rsp_data, 2);
    check("pp_first_tag", rsp_tag, 3);
    check("pp_level_before", cmd_level, 2);
    rsp_ready = 1'b1;
    push(2'd2, 2'd0, 1'b0, 2'b01, 4'h6, acc);
    check("pp_accept", acc, 1);
    check("pp_level_after", cmd_level, 2);
    check("pp_valid_after", rsp_valid, 0);
    exp_d[0] = 5; exp_t[0] = 4;
    exp_d[1] = 7; exp_t[1] = 5;
    exp_d[2] = 1; exp_t[2] = 6;
    collect("pp", 3);

    // Reset while in WAIT with three commands queued.
    push(2'd1, 2'd1, 1'b1, 2'b00, 4'h1, acc);
    push(2'd2, 2'd1, 1'b0, 2'b00, 4'h2, acc);
    push(2'd3, 2'd2, 1'b0, 2'b00, 4'h3, acc);
    push(2'd1, 2'd0, 1'b0, 2'b00, 4'h4, acc);
    push(2'd2, 2'd2, 1'b0, 2'b00, 4'h5, acc);
    check("mid_level_pre", cmd_level, 3);
    check("mid_busy_pre", busy, 1);
    check("mid_alu_pre", {alu_a, alu_b, alu_cin, alu_fun}, {2'd2, 2'd1, 1'b0, 2'b00});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid || busy || (cmd_level != 3'd0)) stale++;
    end
    check("mid_no_stale", stale, 0);
    check_reset("mid_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller that drives the registered 2-bit ALU in `lab_dc` and returns its results. It accepts host operations over a valid/ready port and buffers them in a small FIFO. It issues one operation at a time to the ALU's `a`/`b`/`cin`/`alu_fun` inputs, waits out the ALU's register latency, then captures the 3-bit `out` into a tagged response with valid/ready backpressure. The ALU is the responder; this block is its initiator and result reader.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of 2, minimum 2.
- `TAG_W`, 4: width of the opaque tag carried from command to response.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  equals `!fifo_full`; this is combinational from the registered count.
- `cmd_a`, `cmd_b`  in  2 each  operands.
- `cmd_cin`  in  1  carry-in.
- `cmd_fun`  in  2  ALU function code: 00 add, 10 sub, 01 a>>1, 11 b>>1.
- `cmd_tag`  in  TAG_W  host tag.
- `alu_a`, `alu_b`  out  2 each  registered, connects to the ALU `a`/`b`.
- `alu_cin`  out  1  registered, connects to the ALU `cin`.
- `alu_fun`  out  2  registered, connects to the ALU `alu_fun`.
- `alu_out`  in  3  connects to the ALU `out`, which is registered inside the ALU.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_data`  out  3  captured ALU result.
- `rsp_tag`  out  TAG_W  tag of the command that produced `rsp_data`.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `cmd_level`  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO push:** a command is pushed when `cmd_valid && cmd_ready` at a clock edge. The FIFO holds {a, b, cin, fun, tag}. Pointers wrap modulo FIFO_DEPTH.
- **No full bypass:** when full, `cmd_ready` is 0 even if a pop occurs in the same cycle.
- **Simultaneous push and pop:** a push and a pop in the same cycle leave `cmd_level` unchanged.
- **IDLE:**
  - If the FIFO is non-empty, pop the head, load `alu_*` from it, latch its tag into the in-flight tag register, and go to WAIT.
  - A command pushed into an empty FIFO cannot be popped on the same edge.
- **WAIT:** the ALU registers its result on this edge; go to CAPTURE.
- **CAPTURE:** `rsp_data` <= `alu_out`, `rsp_tag` <= in-flight tag, `rsp_valid` <= 1; go to RESP.
- **RESP:** hold `rsp_valid`, `rsp_data` and `rsp_tag` stable until `rsp_ready`. On the handshake edge:
  - FIFO non-empty: pop the next command, load `alu_*`, keep `rsp_valid` <= 0, go to WAIT.
  - Otherwise: `rsp_valid` <= 0, go to IDLE.
- **Held ALU inputs:** `alu_*` hold their last value between operations, so `alu_out` stays stable.
- **Passthrough:** the block never modifies `alu_out`. The expected results, which the bench must model, are:
  - 00: (a+b+cin) mod 8, with a range of 0..7.
  - 10: (a−b) mod 8; for example 0−1 = 3'b111.
  - 01: a>>1.
  - 11: b>>1.
- **Ordering:** responses return strictly in command order, at most one in flight.

## Timing
- **Reset values:** `rsp_valid`, `rsp_data`, `rsp_tag`, `alu_a`, `alu_b`, `alu_cin` and `alu_fun` are 0; `busy` is 0; `cmd_level` is 0; the FSM is in IDLE; the FIFO is empty. `cmd_ready` is 1 during and after reset.
- **Reset mid-operation:** discards the FIFO contents, the in-flight operation and any pending response immediately, without waiting for a clock edge.
- **Latency:** take the command-accept edge as E0, with the FIFO previously empty and the FSM in IDLE.
  - E1: pop; `alu_*` update.
  - E2: the ALU captures its result.
  - E3: `rsp_valid` rises.
  - `rsp_valid` is first visible in the cycle after E3.
- **Throughput:** with `rsp_ready` held at 1, one response every 3 cycles. The handshake edge doubles as the next issue edge.
- **Backpressure:** while `rsp_ready` is 0, no new issue occurs and `alu_*` do not change. The FIFO keeps accepting commands until full.
- **Host rules:** `cmd_*` are sampled only on handshake edges. The host may drop `cmd_valid` at any time.

## Test plan
1. **Reset outputs:** reset, then idle. All outputs hold their reset values, with `cmd_ready`=1 and `busy`=0.
2. **Single add:** a=3, b=3, cin=1, fun=00, tag=5. `rsp_valid` rises 3 edges after accept with `rsp_data`=7 and `rsp_tag`=5. `busy` falls after the `rsp_ready` handshake.
3. **Sub wrap and shifts:** send sub a=0,b=1; then a>>1 with a=3; then b>>1 with b=2, each with distinct tags. Responses arrive in order as 3'b111, 1, 1 with matching tags, one every 3 cycles while `rsp_ready`=1.
4. **Full FIFO:** hold `rsp_ready`=0 and push 6 commands.
   - The first issues.
   - `cmd_level` reaches 4 and `cmd_ready` drops.
   - `alu_*` and `rsp_*` stay stable.
   - Releasing `rsp_ready` drains all 5 accepted commands in order; the 6th is never accepted while full.
5. **Push and pop together:** push on the same edge a pop occurs from a level of 2. `cmd_level` stays 2.
6. **Reset mid-operation:** assert `rst_n`=0 during WAIT with 3 commands queued. All outputs reach their reset values asynchronously, and no stale response appears after release.
